// File: rtl/disp_pkg.sv
// Shared constants and types for the display front-end controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package disp_pkg;

  localparam int DIG_W = 5;
  localparam int VAL_W = 10;
  localparam int NDIG  = 3;

  // Digit codes 0-9 are numerals; these two are the non-numeric glyphs.
  localparam logic [DIG_W-1:0] DIG_BLANK = 5'd16;
  localparam logic [DIG_W-1:0] DIG_DASH  = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FMT
  } state_t;

endpackage

// File: rtl/disp_prescaler.sv
// Divides clk down to the display scan clock: clk_disp toggles every DIV clk edges.
// Latency: first toggle DIV edges after reset release, then every DIV edges.
// Backpressure: none; free-running and independent of the conversion FSM.
module disp_prescaler
  import disp_pkg::*;
#(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  output logic clk_disp
);

  // DIV = 1 would give a zero-width counter, so keep at least one bit.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1; toggle the scan clock and restart on the wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      clk_disp <= 1'b0;
    end else if (cnt == LAST) begin
      cnt      <= '0;
      clk_disp <= ~clk_disp;
    end else begin
      cnt      <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_ctrl.sv
// Converts a 10-bit value to three display digit codes (double dabble) and drives the scan clock.
// Latency: digits and done appear 11 clk edges after the load&ready edge; one conversion per 12 cycles.
// Backpressure: ready is low while converting; load seen with ready low is dropped, not queued.
// Optional build macro DISP_LZB_EN: blank leading zeros in the hundreds and tens positions.
module disp_ctrl
  import disp_pkg::*;
#(
  parameter int DIV    = 25000,
  parameter int MAXVAL = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value,
  input  logic             load,
  output logic             ready,
  output logic             done,
  output logic [DIG_W-1:0] u,
  output logic [DIG_W-1:0] d,
  output logic [DIG_W-1:0] c,
  output logic             clk_disp
);

  state_t            state;
  logic [VAL_W-1:0]  bin;
  logic [4*NDIG-1:0] bcd;
  logic [4*NDIG-1:0] bcd_adj;
  logic [3:0]        step;
  logic              ovr;
  logic [3:0]        hun, ten, one;

  disp_prescaler #(.DIV(DIV)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .clk_disp (clk_disp)
  );

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign hun = bcd[11:8];
  assign ten = bcd[7:4];
  assign one = bcd[3:0];

  // Conversion FSM; digit registers change only in FMT so no partial result is ever shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      step  <= '0;
      ovr   <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
      u     <= DIG_BLANK;
      d     <= DIG_BLANK;
      c     <= DIG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin   <= value;
            bcd   <= '0;
            step  <= '0;
            ovr   <= (int'(value) > MAXVAL);
            ready <= 1'b0;
            state <= CONV;
          end
        end
        CONV: begin
          // Shift {bcd, bin} left one place using the corrected BCD digits.
          {bcd, bin} <= {bcd_adj[4*NDIG-2:0], bin, 1'b0};
          step       <= step + 4'd1;
          if (step == 4'(VAL_W - 1)) state <= FMT;
        end
        FMT: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
          if (ovr) begin
            u <= DIG_DASH;
            d <= DIG_DASH;
            c <= DIG_DASH;
          end else begin
            u <= {1'b0, one};
`ifdef DISP_LZB_EN
            c <= (hun == 4'd0) ? DIG_BLANK : {1'b0, hun};
            d <= (hun == 4'd0 && ten == 4'd0) ? DIG_BLANK : {1'b0, ten};
`else
            c <= {1'b0, hun};
            d <= {1'b0, ten};
`endif
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/disp_ctrl.md
Name: disp_ctrl

Overview:
- Front-end controller for the 3-digit multiplexed 7-segment display driver.
- Accepts a 10-bit binary value through a load/ready handshake and converts it to three 5-bit digit codes with a sequential double-dabble FSM.
- Applies overrange and leading-zero formatting, then updates the u/d/c digit registers atomically.
- Generates the divided multiplex clock that steps the display driver's digit scan.

Parameters:
- DIV, 25000, clk cycles per half-period of clk_disp; legal range 1 .. 2^20.
- MAXVAL, 999, largest displayable value; any larger value is overrange.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- value  in  10  unsigned binary value to display
- load  in  1  request to convert value; sampled only when ready=1
- ready  out  1  high in IDLE; load is accepted on a clk edge with load&ready
- done  out  1  one-cycle pulse on the cycle u/d/c take new values
- u  out  5  units digit code
- d  out  5  tens digit code
- c  out  5  hundreds digit code
- clk_disp  out  1  registered divided clock for the display driver scan

Behaviour:
- Digit codes: 0-9 = numeral, 16 = blank, 17 = dash.
- Reset, asynchronous and immediate:
  - u = d = c = 16, ready = 1, done = 0, clk_disp = 0.
  - Prescaler count = 0, FSM = IDLE.
  - Reset mid-conversion aborts it; no partial digits ever appear on the outputs.
- FSM states: IDLE, CONV, FMT.
  - IDLE: ready = 1. On load=1 at edge E0, capture value into shift reg, clear 12-bit BCD accumulator and 4-bit step counter, go to CONV, ready → 0.
  - CONV: one step per edge, E1..E10. Each step adds 3 to every BCD nibble ≥5, then shifts {bcd, bin} left by 1. After the 10th step go to FMT.
  - FMT, edge E11: write u/d/c, pulse done = 1 for exactly one cycle, return to IDLE, ready → 1.
- Latency: fixed at 11 edges from the accepting edge to the output update, regardless of value. Throughput is 1 conversion per 12 cycles.
- Formatting in FMT:
  - captured value > MAXVAL: u = d = c = 17 (dashes).
  - otherwise, digits as converted, subject to the Optional Feature.
- load while ready = 0: ignored, not queued. value is only sampled at E0, so changes during CONV/FMT have no effect.
- u/d/c hold their last values between updates. The display never shows transient data.
- Prescaler:
  - Counter runs 0 .. DIV-1 continuously, independent of the FSM.
  - On the wrap edge, clk_disp toggles and the counter returns to 0.
  - DIV = 1 toggles clk_disp every clk edge.
  - Counter width is clog2(DIV), minimum 1.

Optional Feature:
- Macro DISP_LZB_EN enables leading-zero blanking. Defined:
  - c = 16 when the hundreds digit is 0.
  - d = 16 when the hundreds and tens digits are both 0.
  - u is never blanked, so value 0 shows "  0".
  - Dash overrange display is unaffected.
- Not defined: all three numerals are always shown, e.g. 7 → "007".

Decomposition:
- Package disp_pkg holds:
  - digit-code constants DIG_BLANK = 16 and DIG_DASH = 17;
  - DIG_W = 5, VAL_W = 10, NDIG = 3;
  - the FSM state typedef {IDLE, CONV, FMT}.
- One natural sub-module: disp_prescaler (DIV parameter, clk/rst in, clk_disp out).
- The FSM and double-dabble logic stay in disp_ctrl.

Test Plan:
- Reset release, then wait → u = d = c = 16, ready = 1, done = 0; clk_disp first toggles DIV edges after reset release (DIV = 4: toggle every 4 clk edges).
- load with value = 345 → done pulses exactly 11 edges after the accept edge, with c = 3, d = 4, u = 5; ready low for exactly 11 cycles.
- value = 7:
  - with DISP_LZB_EN → c = 16, d = 16, u = 7;
  - without it → c = 0, d = 0, u = 7;
  - value = 0 with DISP_LZB_EN → 16, 16, 0.
- value = 1000 and value = 1023 → c = d = u = 17 after the same 11-edge latency; value = 999 → 9, 9, 9.
- Load 345, then pulse load with 512 at cycle 5 while busy → second request ignored; outputs stay 3, 4, 5 and only one done pulse occurs.
- Assert rst at cycle 6 of a 123 conversion over a prior display of 345 → outputs immediately become 16, 16, 16, ready = 1, and no done pulse follows.
